uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 140 ++++++++++++++
 tb/tb_uart_tx_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// even/odd parity, STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state,  w_state_next;
    logic [BAUD_W-1:0]    r_baud,   w_baud_next;
    logic [IDX_W-1:0]     r_idx,    w_idx_next;
    logic [DATA_BITS-1:0] r_shift,  w_shift_next;
    logic                 r_parity, w_parity_next;
    logic                 r_tx,     w_tx_next;
    logic                 w_bit_end;
    logic                 w_accept;

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_accept  = tx_valid && tx_ready;
    assign tx        = r_tx;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        unique case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_idx_next  = '0;
                if (w_accept) begin
                    w_state_next  = S_START;
                    w_shift_next  = tx_data;
                    w_parity_next = (PARITY_MODE == 2) ? ~(^tx_data) : ^tx_data;
                end
            end
            S_START: begin
                w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                if (w_bit_end) begin
                    if (r_idx == DATA_LAST) begin
                        w_state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end
            end
            S_PARITY: begin
                w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_idx_next   = '0;
                end
            end
            S_STOP: begin
                w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
                if (w_bit_end) begin
                    if (r_idx == STOP_LAST) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // tx is registered from the next state, so the start bit appears on the accepting edge.
    always_comb begin
        tx_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        w_tx_next = 1'b1;
        unique case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three parameter sets, hand-computed frames queued
// by stimulus and checked cycle by cycle by a per-instance line monitor.
`timescale 1ns/1ps
module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string bits;   // line bits in transmission order, '0'/'1'
        int    ncyc;   // cycles to check before an abort, -1 = whole frame
        int    gap;    // required idle-high cycles before this frame, -1 = any
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DB  = (g == 1) ? 7 : 8;
        localparam int PM  = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
        localparam int SB  = (g == 1) ? 2 : 1;
        localparam int CPB = (g == 1) ? 2 : 4;

        logic          rst_n;
        logic [DB-1:0] tx_data;
        logic          tx_valid;
        logic          tx_ready;
        logic          tx;
        logic          busy;
        logic          mon_busy;
        logic          done;
        exp_t          exp_q[$];

        uart_tx_param #(
            .DATA_BITS    (DB),
            .PARITY_MODE  (PM),
            .STOP_BITS    (SB),
            .CLKS_PER_BIT (CPB)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .tx       (tx),
            .busy     (busy)
        );

        task automatic do_reset();
            rst_n    = 1'b0;
            tx_valid = 1'b0;
            tx_data  = '0;
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("cfg%0d reset_state{tx,busy,ready}", g), {tx, busy, tx_ready}, 3'b101);
            @(negedge clk);
            rst_n = 1'b1;
        endtask

        // Waits for tx_ready, presents the word, queues its frame, checks the accepting edge.
        task automatic send(input logic [8:0] d, input string bits, input int gap, input int ncyc);
            exp_t e;
            int   n;
            n = 0;
            @(negedge clk);
            while (tx_ready !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("cfg%0d ready_for_%s", g, bits), tx_ready, 1);
            tx_data  = d[DB-1:0];
            tx_valid = 1'b1;
            e.bits = bits;
            e.ncyc = ncyc;
            e.gap  = gap;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check($sformatf("cfg%0d accept_%s{tx,busy,ready}", g, bits), {tx, busy, tx_ready}, 3'b010);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("cfg%0d frames_pending", g), exp_q.size() + int'(mon_busy), 0);
            repeat (30) @(negedge clk);
            check($sformatf("cfg%0d final_idle{tx,busy,ready}", g), {tx, busy, tx_ready}, 3'b101);
            done = 1'b1;
        endtask

        initial begin : monitor
            exp_t e;
            int   idle_cnt;
            int   n;
            int   nbad_tx;
            int   nbad_ctl;
            logic exp_b;
            idle_cnt = 0;
            mon_busy = 1'b0;
            forever begin
                @(negedge clk);
                if (tx !== 1'b0) begin
                    idle_cnt++;
                    continue;
                end
                check($sformatf("cfg%0d frame_expected", g), exp_q.size() > 0, 1);
                if (exp_q.size() == 0) begin
                    for (int j = 0; j < 1000 && tx !== 1'b1; j++) @(negedge clk);
                    idle_cnt = 0;
                    continue;
                end
                e = exp_q.pop_front();
                mon_busy = 1'b1;
                if (e.gap >= 0)
                    check($sformatf("cfg%0d gap_before_%s", g, e.bits), idle_cnt, e.gap);
                n        = (e.ncyc > 0) ? e.ncyc : e.bits.len() * CPB;
                nbad_tx  = 0;
                nbad_ctl = 0;
                for (int k = 0; k < n; k++) begin
                    if (k > 0) @(negedge clk);
                    exp_b = (e.bits.getc(k / CPB) == 8'h31);
                    if (tx !== exp_b) nbad_tx++;
                    if (busy !== 1'b1 || tx_ready !== 1'b0) nbad_ctl++;
                end
                check($sformatf("cfg%0d frame_%s bad_tx_cycles", g, e.bits), nbad_tx, 0);
                check($sformatf("cfg%0d frame_%s bad_busy_ready_cycles", g, e.bits), nbad_ctl, 0);
                if (e.ncyc <= 0) begin
                    @(negedge clk);
                    check($sformatf("cfg%0d idle_after_%s{tx,busy,ready}", g, e.bits),
                          {tx, busy, tx_ready}, 3'b101);
                    idle_cnt = 1;
                end else begin
                    for (int j = 0; j < 1000 && tx !== 1'b1; j++) @(negedge clk);
                    check($sformatf("cfg%0d line_high_after_abort", g), tx, 1);
                    idle_cnt = 0;
                end
                mon_busy = 1'b0;
            end
        end

        if (g == 0) begin : g_stim
            initial begin
                exp_t e;
                done = 1'b0;
                do_reset();
                send(9'h055, "01010101001", -1, -1);
                tx_valid = 1'b0;
                send(9'h001, "01000000011", -1, -1);
                tx_valid = 1'b0;
                // tx_valid held high across both words
                send(9'h0A5, "01010010101", -1, -1);
                send(9'h03C, "00011110001", 1, -1);
                tx_valid = 1'b0;
                send(9'h00F, "01111000001", -1, -1);
                tx_valid = 1'b0;
                repeat (10) @(negedge clk);
                tx_data  = 8'hF0;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 8'hAA;
                // reset lands during data bit 3 (cycles 16..19 after acceptance)
                send(9'h0C3, "01100001101", -1, 18);
                tx_valid = 1'b0;
                repeat (17) @(posedge clk);
                @(negedge clk);
                rst_n    = 1'b0;
                tx_valid = 1'b1;
                tx_data  = 8'h12;
                @(posedge clk);
                #1;
                check("cfg0 abort{tx,busy,ready}", {tx, busy, tx_ready}, 3'b101);
                @(posedge clk);
                #1;
                check("cfg0 reset_beats_valid{tx,busy,ready}", {tx, busy, tx_ready}, 3'b101);
                @(negedge clk);
                rst_n   = 1'b1;
                tx_data = 8'hFF;
                e.bits  = "01111111101";
                e.ncyc  = -1;
                e.gap   = -1;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                check("cfg0 first_edge_after_reset{tx,busy,ready}", {tx, busy, tx_ready}, 3'b010);
                tx_valid = 1'b0;
                drain();
            end
        end else if (g == 1) begin : g_stim
            initial begin
                done = 1'b0;
                do_reset();
                send(9'h041, "0100000111", -1, -1);
                tx_valid = 1'b0;
                send(9'h02A, "0010101011", -1, -1);
                send(9'h07F, "0111111111", 1, -1);
                tx_valid = 1'b0;
                drain();
            end
        end else begin : g_stim
            initial begin
                done = 1'b0;
                do_reset();
                send(9'h055, "01010101011", -1, -1);
                tx_valid = 1'b0;
                send(9'h007, "01110000001", -1, -1);
                tx_valid = 1'b0;
                drain();
            end
        end
    end

    initial begin
        int n;
        n = 0;
        #1;
        while (!(g_cfg[0].done === 1'b1 && g_cfg[1].done === 1'b1 && g_cfg[2].done === 1'b1)
               && n < 50000) begin
            @(posedge clk);
            n++;
        end
        check("all_configs_done", n < 50000, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
